ufm_block_driver: RTL and testbench
===================================

Name: ufm_block_driver

Overview:
- Initiator counterpart to the user functional module. Host/AXI side fills a 64-word input buffer and pulses start.
- The block runs the functional module's handshake: raises its start, streams words 0..63 during LOAD, waits through PROCESS, captures 64 result words during SAVE, then releases start.
- Results sit in an output buffer readable by the host; a sticky done/error status feeds the CONFIG_PROCESS_DONE (0x89) register.

Parameters:
- DEPTH, 64, words per block; fixed at 64 because the functional module's index range is fixed.
- TIMEOUT_CYCLES, 4096, maximum cycles allowed in any wait state before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- host_wr_en  in  1  write input buffer
- host_wr_addr  in  6  input buffer index
- host_wr_data  in  32  input word
- host_rd_addr  in  6  output buffer index
- host_rd_data  out  32  output word, registered, 1-cycle latency
- host_start  in  1  one-cycle request to run a block
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  sticky; block completed successfully
- error  out  1  sticky; timeout abort
- fu_start  out  1  start to functional module
- fu_data_in_addr  out  8  load index
- fu_data_in  out  32  in_buf[fu_data_in_addr], combinational
- fu_data_out_addr  in  8  functional module save index
- fu_data_out  in  32  functional module result word
- fu_state  in  4  functional module state

Behaviour:
- Reset (async, rst_n=0): state IDLE, fu_start=0, fu_data_in_addr=0, busy=0, done=0, error=0, host_rd_data=0, timeout counter=0. Buffer contents are not reset.
- Functional state codes: IDLE=0, LOAD=1, PROCESS=2, SAVE=3, DONE=4.
- IDLE:
  - host_start clears done and error, sets busy, and moves to ARM.
  - Host writes are accepted only in IDLE. Writes while busy are dropped silently.
  - host_start while busy is ignored.
- ARM: fu_start=1 and fu_data_in_addr=0. Move to LOAD on the cycle fu_state==1 is seen.
- LOAD:
  - Each cycle fu_state==1: if fu_data_in_addr<63, increment it; at 63, hold it and move to WAIT_SAVE.
  - The address never wraps, so the functional module writes word k at index k and completes on index 63.
- WAIT_SAVE: fu_start stays 1. Move to CAPTURE when fu_state==3.
- CAPTURE:
  - Each cycle fu_state==3 and fu_data_out_addr<64: out_buf[fu_data_out_addr[5:0]] <= fu_data_out.
  - Addresses >=64 are ignored.
  - Move to RELEASE when fu_state==4.
- RELEASE: fu_start=0 and fu_data_in_addr returns to 0. On fu_state==0, set done=1, busy=0, and return to IDLE.
- Timeout:
  - The counter resets on every state change and increments in ARM, LOAD, WAIT_SAVE, CAPTURE and RELEASE.
  - At TIMEOUT_CYCLES-1: error=1, fu_start=0, busy=0, state IDLE. out_buf contents are undefined.
- Host read: host_rd_data <= out_buf[host_rd_addr] every cycle. A read colliding with a same-cycle capture write at the same index returns the old value.
- fu_start is held high through DONE so the functional module cannot re-trigger. It drops only in RELEASE or on abort.
- Reset mid-operation: everything returns to reset values immediately. The functional module sees fu_start=0.

Decomposition:
- Shared package ufm_pkg:
  - functional-state enum (IDLE..DONE, 4-bit)
  - driver state enum
  - UFM_DEPTH=64
  - CONFIG_PROCESS_DONE=8'h89
- Sub-module ufm_word_ram: 64x32, one write port and one synchronous read port. Instantiate twice: in_buf (host write, combinational read for fu_data_in) and out_buf (capture write, host read). in_buf needs a combinational-read option.

Test Plan:
- Write in_buf[k]=k for k=0..63, pulse host_start, pair with the inverter functional module -> done=1, error=0, busy=0; host read of index k returns ~k (k=5 -> 32'hFFFFFFFA); fu_data_in_addr sequence 0..63 with no repeats.
- Pulse host_start again mid-run (in WAIT_SAVE) -> ignored; exactly one LOAD sequence observed; done set once.
- Host write to index 10 while busy -> dropped; the next run's result[10] equals ~(original value).
- Hold fu_state at 2 forever, TIMEOUT_CYCLES=16 -> error=1 after 16 cycles in WAIT_SAVE, fu_start=0, busy=0, done=0.
- Assert rst_n=0 asynchronously at LOAD index 30 -> outputs reset within the same cycle; fu_start=0, state IDLE; a subsequent full run completes correctly.
- fu_data_out_addr reaching 64 in SAVE -> no buffer write; result[0] is not corrupted.

Source files
------------

// File: rtl/ufm_pkg.sv
// Shared types and constants for the user-functional-module block driver.
package ufm_pkg;

  localparam int unsigned UFM_DEPTH = 64;
  localparam logic [7:0] CONFIG_PROCESS_DONE = 8'h89;

  typedef enum logic [3:0] {
    FuIdle    = 4'd0,
    FuLoad    = 4'd1,
    FuProcess = 4'd2,
    FuSave    = 4'd3,
    FuDone    = 4'd4
  } fu_state_e;

  typedef enum logic [2:0] {
    DrvIdle,
    DrvArm,
    DrvLoad,
    DrvWaitSave,
    DrvCapture,
    DrvRelease
  } drv_state_e;

endpackage

// File: rtl/ufm_word_ram.sv
// Single-write-port word RAM with either a combinational or a registered read port.
module ufm_word_ram #(
  parameter int unsigned Depth    = 64,
  parameter int unsigned Width    = 32,
  parameter int unsigned AddrW    = $clog2(Depth),
  parameter bit          CombRead = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (CombRead) begin : g_comb_read
    logic unused_rst;
    assign unused_rst = rst_n;
    assign rdata      = mem[raddr];
  end else begin : g_sync_read
    // Non-blocking write means a same-address read returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata <= '0;
      else        rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ufm_block_driver.sv
// Initiator for the user functional module: streams a 64-word block in, captures 64 results,
// and reports sticky done/error status.
module ufm_block_driver import ufm_pkg::*; #(
  parameter int unsigned DEPTH          = UFM_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_wr_en,
  input  logic [5:0]  host_wr_addr,
  input  logic [31:0] host_wr_data,
  input  logic [5:0]  host_rd_addr,
  output logic [31:0] host_rd_data,
  input  logic        host_start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        fu_start,
  output logic [7:0]  fu_data_in_addr,
  output logic [31:0] fu_data_in,
  input  logic [7:0]  fu_data_out_addr,
  input  logic [31:0] fu_data_out,
  input  logic [3:0]  fu_state
);

  localparam int unsigned CntW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      LastIdx = 8'(DEPTH - 1);

  drv_state_e      state_q;
  logic [CntW-1:0] tmo_cnt_q;
  logic            in_we;
  logic            cap_we;

  assign in_we  = host_wr_en && (state_q == DrvIdle);
  // WAIT_SAVE is included so the first SAVE word, seen on the transition cycle, is kept.
  assign cap_we = ((state_q == DrvWaitSave) || (state_q == DrvCapture)) &&
                  (fu_state == FuSave) && (fu_data_out_addr < 8'(DEPTH));

  ufm_word_ram #(
    .Depth    (DEPTH),
    .Width    (32),
    .CombRead (1'b1)
  ) u_in_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (in_we),
    .waddr (host_wr_addr),
    .wdata (host_wr_data),
    .raddr (fu_data_in_addr[5:0]),
    .rdata (fu_data_in)
  );

  ufm_word_ram #(
    .Depth    (DEPTH),
    .Width    (32),
    .CombRead (1'b0)
  ) u_out_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cap_we),
    .waddr (fu_data_out_addr[5:0]),
    .wdata (fu_data_out),
    .raddr (host_rd_addr),
    .rdata (host_rd_data)
  );

  // The timeout counter restarts on every state change and on every streamed/captured word,
  // so it bounds stalls rather than the length of a healthy transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= DrvIdle;
      tmo_cnt_q       <= '0;
      fu_start        <= 1'b0;
      fu_data_in_addr <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == DrvIdle) ? '0 : tmo_cnt_q + CntW'(1);
      if ((state_q != DrvIdle) && (tmo_cnt_q == TmoLast)) begin
        state_q         <= DrvIdle;
        tmo_cnt_q       <= '0;
        fu_start        <= 1'b0;
        fu_data_in_addr <= '0;
        busy            <= 1'b0;
        error           <= 1'b1;
      end else begin
        unique case (state_q)
          DrvIdle: begin
            if (host_start) begin
              done            <= 1'b0;
              error           <= 1'b0;
              busy            <= 1'b1;
              fu_start        <= 1'b1;
              fu_data_in_addr <= '0;
              state_q         <= DrvArm;
            end
          end
          DrvArm: begin
            // Word 0 is consumed on the cycle LOAD is first seen.
            if (fu_state == FuLoad) begin
              fu_data_in_addr <= 8'd1;
              tmo_cnt_q       <= '0;
              state_q         <= DrvLoad;
            end
          end
          DrvLoad: begin
            if (fu_state == FuLoad) begin
              tmo_cnt_q <= '0;
              if (fu_data_in_addr == LastIdx) state_q <= DrvWaitSave;
              else fu_data_in_addr <= fu_data_in_addr + 8'd1;
            end
          end
          DrvWaitSave: begin
            if (fu_state == FuSave) begin
              tmo_cnt_q <= '0;
              state_q   <= DrvCapture;
            end
          end
          DrvCapture: begin
            if (fu_state == FuDone) begin
              fu_start        <= 1'b0;
              fu_data_in_addr <= '0;
              tmo_cnt_q       <= '0;
              state_q         <= DrvRelease;
            end else if (cap_we) begin
              tmo_cnt_q <= '0;
            end
          end
          DrvRelease: begin
            if (fu_state == FuIdle) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              tmo_cnt_q <= '0;
              state_q   <= DrvIdle;
            end
          end
          default: state_q <= DrvIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ufm_block_driver.sv
// Bench for ufm_block_driver: inverter functional-module stand-in, buffer model, directed runs.
module tb_ufm_block_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        host_wr_en;
  logic [5:0]  host_wr_addr;
  logic [31:0] host_wr_data;
  logic [5:0]  host_rd_addr;
  logic [31:0] host_rd_data;
  logic        host_start;
  logic        busy, done, error, fu_start;
  logic [7:0]  fu_data_in_addr;
  logic [31:0] fu_data_in;
  logic [7:0]  fu_data_out_addr;
  logic [31:0] fu_data_out;
  logic [3:0]  fu_state;

  // Second instance with a short timeout, driven directly.
  logic        t_host_start;
  logic [3:0]  t_fu_state;
  logic [31:0] t_host_rd_data, t_fu_data_in;
  logic        t_busy, t_done, t_error, t_fu_start;
  logic [7:0]  t_fu_data_in_addr;

  int checks = 0;
  int errors = 0;

  ufm_block_driver u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .host_wr_en       (host_wr_en),
    .host_wr_addr     (host_wr_addr),
    .host_wr_data     (host_wr_data),
    .host_rd_addr     (host_rd_addr),
    .host_rd_data     (host_rd_data),
    .host_start       (host_start),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .fu_start         (fu_start),
    .fu_data_in_addr  (fu_data_in_addr),
    .fu_data_in       (fu_data_in),
    .fu_data_out_addr (fu_data_out_addr),
    .fu_data_out      (fu_data_out),
    .fu_state         (fu_state)
  );

  ufm_block_driver #(.TIMEOUT_CYCLES(16)) u_dut_tmo (
    .clk              (clk),
    .rst_n            (rst_n),
    .host_wr_en       (1'b0),
    .host_wr_addr     (6'd0),
    .host_wr_data     (32'd0),
    .host_rd_addr     (6'd0),
    .host_rd_data     (t_host_rd_data),
    .host_start       (t_host_start),
    .busy             (t_busy),
    .done             (t_done),
    .error            (t_error),
    .fu_start         (t_fu_start),
    .fu_data_in_addr  (t_fu_data_in_addr),
    .fu_data_in       (t_fu_data_in),
    .fu_data_out_addr (8'd0),
    .fu_data_out      (32'd0),
    .fu_state         (t_fu_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inverter functional module: loads 64 words by the driver's index, returns ~word.
  logic [31:0] fu_mem [64];
  int          fu_cnt;
  bit          overrun_en;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_state         <= 4'd0;
      fu_cnt           <= 0;
      fu_data_out_addr <= 8'd0;
      fu_data_out      <= 32'd0;
    end else begin
      case (fu_state)
        4'd0: if (fu_start) fu_state <= 4'd1;
        4'd1: begin
          fu_mem[fu_data_in_addr[5:0]] <= fu_data_in;
          if (fu_data_in_addr == 8'd63) begin
            fu_state <= 4'd2;
            fu_cnt   <= 0;
          end
        end
        4'd2: begin
          if (fu_cnt == 5) begin
            fu_state         <= 4'd3;
            fu_cnt           <= 0;
            fu_data_out_addr <= 8'd0;
            fu_data_out      <= ~fu_mem[0];
          end else fu_cnt <= fu_cnt + 1;
        end
        4'd3: begin
          if (fu_cnt < 63) begin
            fu_cnt           <= fu_cnt + 1;
            fu_data_out_addr <= 8'(fu_cnt + 1);
            fu_data_out      <= ~fu_mem[fu_cnt + 1];
          end else if (overrun_en && fu_cnt < 65) begin
            fu_cnt           <= fu_cnt + 1;
            fu_data_out_addr <= (fu_cnt == 63) ? 8'd64 : 8'd128;
            fu_data_out      <= 32'h1234_5678;
          end else fu_state <= 4'd4;
        end
        4'd4: if (!fu_start) fu_state <= 4'd0;
        default: fu_state <= 4'd0;
      endcase
    end
  end

  // Model: host-visible buffers and the 1-cycle registered read.
  logic [31:0] in_m  [64];
  bit          in_known [64];
  logic [31:0] out_m [64];
  bit          out_known [64];
  logic [31:0] exp_rd;
  bit          exp_rd_valid;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_rd       <= 32'd0;
      exp_rd_valid <= 1'b1;
    end else begin
      exp_rd       <= out_m[host_rd_addr];
      exp_rd_valid <= out_known[host_rd_addr];
      if (fu_state == 4'd3 && fu_data_out_addr < 8'd64) begin
        out_m[fu_data_out_addr[5:0]]     <= fu_data_out;
        out_known[fu_data_out_addr[5:0]] <= 1'b1;
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      if (exp_rd_valid) check("host_rd_data", host_rd_data, exp_rd);
      if (in_known[fu_data_in_addr[5:0]])
        check("fu_data_in", fu_data_in, in_m[fu_data_in_addr[5:0]]);
      check("fu_start_without_busy", {31'd0, fu_start & ~busy}, 32'd0);
      check("status_while_busy", {31'd0, busy & (done | error)}, 32'd0);
      check("done_and_error", {31'd0, done & error}, 32'd0);
    end
  end

  logic [7:0] load_seq [$];
  int         done_rises;
  logic       done_d = 1'b0;
  always @(negedge clk) begin
    if (rst_n && fu_state == 4'd1) load_seq.push_back(fu_data_in_addr);
    if (done && !done_d) done_rises++;
    done_d = done;
  end

  task automatic host_write(input int a, input logic [31:0] d, input bit accept);
    host_wr_en   = 1'b1;
    host_wr_addr = 6'(a);
    host_wr_data = d;
    @(posedge clk);
    if (accept) begin
      in_m[a]     = d;
      in_known[a] = 1'b1;
    end
    @(negedge clk);
    host_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    load_seq.delete();
    done_rises = 0;
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completes"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic read_check(input string name, input int idx, input logic [31:0] exp);
    host_rd_addr = 6'(idx);
    @(negedge clk);
    check(name, host_rd_data, exp);
  endtask

  task automatic check_load_seq(input string name);
    bit ok = (load_seq.size() == 64);
    if (ok) for (int i = 0; i < 64; i++) if (load_seq[i] !== 8'(i)) ok = 1'b0;
    check(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    host_wr_en   = 1'b0;
    host_wr_addr = 6'd0;
    host_wr_data = 32'd0;
    host_rd_addr = 6'd0;
    host_start   = 1'b0;
    overrun_en   = 1'b0;
    t_host_start = 1'b0;
    t_fu_state   = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_fu_start", {31'd0, fu_start}, 32'd0);
    check("rst_fu_addr", {24'd0, fu_data_in_addr}, 32'd0);
    check("rst_rd_data", host_rd_data, 32'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Run 1: in[k]=k.
    for (int k = 0; k < 64; k++) host_write(k, 32'(k), 1'b1);
    pulse_start();
    check("run1_busy", {31'd0, busy}, 32'd1);
    check("run1_fu_start", {31'd0, fu_start}, 32'd1);
    wait_idle("run1");
    check("run1_done", {31'd0, done}, 32'd1);
    check("run1_error", {31'd0, error}, 32'd0);
    check("run1_fu_start_low", {31'd0, fu_start}, 32'd0);
    check_load_seq("run1_load_seq");
    read_check("run1_res5", 5, 32'hFFFF_FFFA);
    read_check("run1_res0", 0, 32'hFFFF_FFFF);
    read_check("run1_res63", 63, 32'hFFFF_FFC0);
    for (int k = 0; k < 64; k++) begin
      host_rd_addr = 6'(k);
      @(negedge clk);
    end

    // Run 2: new pattern; restart and host write mid-run must be ignored.
    for (int k = 0; k < 64; k++) host_write(k, 32'(k) ^ 32'hA5A5_0000, 1'b1);
    pulse_start();
    n = 0;
    while (fu_state != 4'd2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("run2_reach_process", {28'd0, fu_state}, 32'd2);
    host_start = 1'b1;
    host_write(10, 32'hDEAD_BEEF, 1'b0);
    host_start = 1'b0;
    wait_idle("run2");
    repeat (4) @(negedge clk);
    check("run2_done_once", 32'(done_rises), 32'd1);
    check("run2_single_load", 32'(load_seq.size()), 32'd64);
    check("run2_idle_after", {31'd0, busy}, 32'd0);
    read_check("run2_res10", 10, 32'h5A5A_FFF5);

    // Run 3: functional module also presents indices 64 and 128 in SAVE.
    overrun_en = 1'b1;
    pulse_start();
    wait_idle("run3");
    overrun_en = 1'b0;
    check("run3_done", {31'd0, done}, 32'd1);
    read_check("run3_res0", 0, 32'h5A5A_FFFF);
    read_check("run3_res10", 10, 32'h5A5A_FFF5);

    // Run 4: asynchronous reset at LOAD index 30, then a full run.
    for (int k = 0; k < 64; k++) host_write(k, 32'(k) + 32'h100, 1'b1);
    pulse_start();
    n = 0;
    while (!(fu_state == 4'd1 && fu_data_in_addr == 8'd30) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("run4_reach_idx30", {24'd0, fu_data_in_addr}, 32'd30);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_fu_start", {31'd0, fu_start}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_fu_addr", {24'd0, fu_data_in_addr}, 32'd0);
    check("midrst_rd_data", host_rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_still_idle", {31'd0, busy}, 32'd0);
    pulse_start();
    wait_idle("run4");
    check("run4_done", {31'd0, done}, 32'd1);
    check_load_seq("run4_load_seq");
    read_check("run4_res30", 30, 32'hFFFF_FEE1);
    read_check("run4_res5", 5, 32'hFFFF_FEFA);

    // Timeout: short-timeout instance stalls in PROCESS after a complete LOAD.
    t_host_start = 1'b1;
    @(negedge clk);
    t_host_start = 1'b0;
    check("tmo_busy", {31'd0, t_busy}, 32'd1);
    check("tmo_fu_start", {31'd0, t_fu_start}, 32'd1);
    t_fu_state = 4'd1;
    repeat (64) @(negedge clk);
    t_fu_state = 4'd2;
    check("tmo_load_end_addr", {24'd0, t_fu_data_in_addr}, 32'd63);
    repeat (15) @(negedge clk);
    check("tmo_not_yet_error", {31'd0, t_error}, 32'd0);
    check("tmo_not_yet_busy", {31'd0, t_busy}, 32'd1);
    @(negedge clk);
    check("tmo_error", {31'd0, t_error}, 32'd1);
    check("tmo_fu_start_low", {31'd0, t_fu_start}, 32'd0);
    check("tmo_busy_low", {31'd0, t_busy}, 32'd0);
    check("tmo_done_low", {31'd0, t_done}, 32'd0);
    t_fu_state = 4'd0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
